// File: rtl/lsu_apb_master_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// strobe patterns and the request-legality helpers used at accept time.
package lsu_apb_master_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] STRB_B = 4'b0001;
   localparam logic [3:0] STRB_H = 4'b0011;
   localparam logic [3:0] STRB_W = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } lsu_state_t;

   function automatic logic func3_valid(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // func3[1:0] encodes the access size for both loads and stores.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
             ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_apb_master_load_extend.sv
// Picks the addressed byte/half out of an APB read word and sign- or
// zero-extends it according to the load's func3.
module load_extend
   import lsu_apb_master_pkg::*;
(
   input  logic [2:0]  func3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] prdata_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (addr_lo_i)
         2'd0:    byte_sel = prdata_i[7:0];
         2'd1:    byte_sel = prdata_i[15:8];
         2'd2:    byte_sel = prdata_i[23:16];
         default: byte_sel = prdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? prdata_i[31:16] : prdata_i[15:0];
   end

   always_comb begin
      unique case (func3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_o = {24'h0, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_o = {16'h0, half_sel};
         default: data_o = prdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_apb_master.sv
// RV32I load/store unit: one request at a time, issued as an APB transfer
// with wait-state support, a bounded ACCESS timeout and extended load data.
module lsu_apb_master
   import lsu_apb_master_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_func3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              busy,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [31:0]       pwdata,
   output logic [3:0]        pstrb,
   input  logic [31:0]       prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        func3_q, func3_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        strb_q, strb_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0] lane_wdata;
   logic [3:0]  lane_strb;
   logic [31:0] load_data;

   load_extend u_load_extend (
      .func3_i   (func3_q),
      .addr_lo_i (addr_q[1:0]),
      .prdata_i  (prdata),
      .data_o    (load_data)
   );

   // Store data is replicated across lanes so the slave can take any byte/half.
   always_comb begin
      unique case (req_func3[1:0])
         2'b00: begin
            lane_wdata = {4{req_wdata[7:0]}};
            lane_strb  = STRB_B << req_addr[1:0];
         end
         2'b01: begin
            lane_wdata = {2{req_wdata[15:0]}};
            lane_strb  = STRB_H << req_addr[1:0];
         end
         default: begin
            lane_wdata = req_wdata;
            lane_strb  = STRB_W;
         end
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      state_d = state_q;
      addr_d  = addr_q;
      func3_d = func3_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               func3_d = req_func3;
               we_d    = req_we;
               wdata_d = req_we ? lane_wdata : 32'h0;
               strb_d  = req_we ? lane_strb : 4'h0;
               rdata_d = 32'h0;
               err_d   = 1'b0;
               cnt_d   = '0;
               if (!func3_valid(req_func3) || misaligned(req_func3, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            // A ready on the final allowed cycle still wins over the timeout.
            if (pready) begin
               err_d   = pslverr;
               rdata_d = (we_q || pslverr) ? 32'h0 : load_data;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               rdata_d = 32'h0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         func3_q <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         func3_q <= func3_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
   assign psel      = (state_q == SETUP) || (state_q == ACCESS);
   assign penable   = (state_q == ACCESS);
   assign paddr     = {addr_q[ADDR_W-1:2], 2'b00};
   assign pwrite    = we_q;
   assign pwdata    = wdata_q;
   assign pstrb     = strb_q;

endmodule

// File: tb/tb_lsu_apb_master.sv
// Randomized bench for lsu_apb_master: a transaction-level model predicts
// latency, APB fields and response, and every cycle of each op is compared.
module tb_lsu_apb_master;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we;
   logic [2:0]  req_func3;
   logic [31:0] req_addr, req_wdata;
   logic        busy, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata, paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;

   int total = 0;
   int bad   = 0;

   lsu_apb_master #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_func3 (req_func3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic int access_size(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
      int unsigned b, h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (8 * a)) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   // One op: start in an IDLE cycle (c0), run to the expected RESP cycle.
   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word,
                         input int waits, input logic slverr);
      bit          legal, reject, tmo;
      int          size, resp;
      logic [3:0]  exp_strb, base;
      logic [31:0] exp_wd, exp_rd;
      logic        exp_err;

      size   = access_size(f3);
      legal  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
      reject = !legal || ((addr % size) != 0);
      tmo    = !reject && (waits >= TIMEOUT);
      resp   = reject ? 1 : tmo ? 2 + TIMEOUT : 3 + waits;
      exp_err = reject || tmo || slverr;
      exp_rd  = (exp_err || we) ? 32'h0 : model_load(f3, addr[1:0], word);
      base    = (size == 1) ? 4'b0001 : 4'b0011;
      exp_strb = !we ? 4'h0 : (size == 4) ? 4'hF : base << addr[1:0];
      exp_wd   = (size == 1) ? wdata[7:0] * 32'h0101_0101 :
                 (size == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;

      @(negedge clk);
      check("idle_ctl", {busy, psel, penable, rsp_valid}, 4'b0000);
      req_valid = 1'b1;
      req_we    = we;
      req_func3 = f3;
      req_addr  = addr;
      req_wdata = wdata;
      pready    = 1'b0;
      pslverr   = 1'b0;

      for (int n = 1; n <= resp; n++) begin
         @(negedge clk);
         if (n == resp) begin
            check("resp_ctl", {busy, psel, penable, rsp_valid}, 4'b1001);
            check("rsp_err", rsp_err, exp_err);
            check("rsp_rdata", rsp_rdata, exp_rd);
         end else begin
            check(n == 1 ? "setup_ctl" : "access_ctl", {busy, psel, penable, rsp_valid},
                  n == 1 ? 4'b1100 : 4'b1110);
            check("paddr", paddr, {addr[31:2], 2'b00});
            check("pwrite_pstrb", {pwrite, pstrb}, {we, exp_strb});
            if (we) check("pwdata", pwdata, exp_wd);
         end
         // Garbage requests while busy must be ignored.
         req_valid = (n < resp) ? 1'($urandom_range(0, 1)) : 1'b0;
         req_addr  = $urandom;
         req_func3 = 3'($urandom);
         req_we    = 1'($urandom);
         if (!reject && n >= 2 && n < resp && (n - 2) == waits) begin
            pready  = 1'b1;
            pslverr = slverr;
            prdata  = word;
         end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = $urandom;
         end
      end
   endtask

   initial begin
      logic [2:0] load_f3 [8];
      logic [2:0] f3;
      logic       we;

      load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

      #3;
      check("rst_ctl", {busy, rsp_valid, rsp_err, psel, penable, pwrite, pstrb}, 10'h0);
      check("rst_data", {rsp_rdata, paddr}, 64'h0);
      check("rst_pwdata", pwdata, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Directed cases.
      run_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      run_op(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 1'b0);
      run_op(1'b1, 3'b001, 32'h202, 32'h1234_5678, 32'h0, 1, 1'b0);
      run_op(1'b0, 3'b000, 32'h102, 32'h0, 32'h1280_FF00, 0, 1'b0);
      run_op(1'b0, 3'b100, 32'h102, 32'h0, 32'h1280_FF00, 0, 1'b0);
      run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_3C5A, 0, 1'b0);
      run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_3C5A, 0, 1'b0);
      run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
      run_op(1'b0, 3'b010, 32'h44, 32'h0, 32'h1111_2222, 9, 1'b0);
      run_op(1'b1, 3'b010, 32'h102, 32'h5555_AAAA, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b001, 32'h301, 32'h0, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 0, 1'b0);
      run_op(1'b0, 3'b010, 32'h80, 32'h0, 32'h7777_8888, 1, 1'b1);
      run_op(1'b1, 3'b010, 32'h84, 32'h0BAD_0BAD, 32'h0, 2, 1'b1);

      // Reset while in ACCESS: transfer aborted, no response.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h500;
      pready = 1'b0; pslverr = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_ctl", {busy, psel, penable, rsp_valid}, 4'b1110);
      reset = 1'b1;
      #1;
      check("mid_rst_ctl", {busy, psel, penable, rsp_valid, rsp_err}, 5'b00000);
      check("mid_rst_paddr", paddr, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_quiet", {busy, psel, rsp_valid}, 3'b000);
      end

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = we ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 7)];
         run_op(we, f3, $urandom, $urandom, $urandom, $urandom_range(0, TIMEOUT + 1),
                ($urandom_range(0, 5) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
